// File: rtl/timer_periph.sv
// timer_periph: memory-mapped prescaled timer.
// Takes the software config word (EN, MODE, CLR, LOAD) and returns a status
// word (COUNT, DONE, BUSY, PERIODS) built purely from registers.
module timer_periph #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] config_register,
    output logic [31:0] status_register
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Prescaler value on which a count tick fires.
    localparam logic [15:0] TICK_LAST = 16'(PRESCALE - 1);

    state_t      r_state;
    logic [23:0] r_count;
    logic        r_done;
    logic        r_busy;
    logic [5:0]  r_periods;
    logic [15:0] r_presc;
    logic        r_en_q;
    logic        r_clr_q;

    logic        w_en;
    logic        w_mode;
    logic        w_clr;
    logic [23:0] w_load;
    logic        w_en_rise;
    logic        w_clr_rise;
    logic        w_tick;
    logic [5:0]  w_periods_base;
    logic        w_unused_cfg;

    assign w_en   = config_register[0];
    assign w_mode = config_register[1];
    assign w_clr  = config_register[2];
    assign w_load = config_register[31:8];

    // Reserved config bits carry no meaning for this block.
    assign w_unused_cfg = ^config_register[7:3];

    assign w_en_rise  = w_en & ~r_en_q;
    assign w_clr_rise = w_clr & ~r_clr_q;
    assign w_tick     = (r_presc == TICK_LAST);

    // A clear arriving with a completion is applied first, so the
    // completion counts from zero.
    assign w_periods_base = w_clr_rise ? 6'd0 : r_periods;

    assign status_register = {r_periods, r_busy, r_done, r_count};

    // Timer FSM, edge detectors, counters and registered status fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= 24'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_periods <= 6'd0;
            r_presc   <= 16'd0;
            r_en_q    <= 1'b0;
            r_clr_q   <= 1'b0;
        end else begin
            r_en_q  <= w_en;
            r_clr_q <= w_clr;

            if (w_clr_rise) begin
                r_done    <= 1'b0;
                r_periods <= 6'd0;
            end

            case (r_state)
                S_IDLE, S_HALT: begin
                    if (w_en_rise) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_count <= 24'd0;
                        r_presc <= 16'd0;
                        r_done  <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (!w_en) begin
                        // Abandon the run; count and done stay visible.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_presc <= 16'd0;
                    end else if (w_tick) begin
                        r_presc <= 16'd0;
                        // Live LOAD compare: >= so a lowered limit never wraps.
                        if (r_count >= w_load) begin
                            r_done    <= 1'b1;
                            r_periods <= 6'(w_periods_base + 6'd1);
                            if (w_mode) begin
                                r_count <= 24'd0;
                            end else begin
                                r_state <= S_HALT;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_count <= 24'(r_count + 24'd1);
                        end
                    end else begin
                        r_presc <= 16'(r_presc + 16'd1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph: two instances (prescale 1 and 4) share config and
// reset; each is compared every cycle against a cycle-count model, and
// directed literal expectations pin the model.
module tb_timer_periph;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg = 32'd0;
    logic [31:0] s1;
    logic [31:0] s4;

    int checks = 0;
    int errors = 0;

    timer_periph #(.PRESCALE(1)) u_p1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .config_register (cfg),
        .status_register (s1)
    );

    timer_periph #(.PRESCALE(4)) u_p4 (
        .clk             (clk),
        .reset_n         (reset_n),
        .config_register (cfg),
        .status_register (s4)
    );

    always #5 clk = ~clk;

    // Model: a run is described by edges elapsed since its start edge;
    // a tick is every p-th elapsed edge.
    typedef struct {
        int count;
        bit done;
        int periods;
        bit run;
        int cyc;
        bit en_q;
        bit clr_q;
    } m_t;

    m_t m1;
    m_t m4;

    function automatic m_t m_zero();
        m_t z;
        z.count = 0; z.done = 0; z.periods = 0; z.run = 0;
        z.cyc = 0; z.en_q = 0; z.clr_q = 0;
        return z;
    endfunction

    function automatic m_t m_step(m_t s, logic [31:0] c, int p);
        m_t n;
        bit en, mode, clr, er, cr;
        int load;
        n = s;
        en = c[0]; mode = c[1]; clr = c[2];
        load = int'(c[31:8]);
        er = en && !s.en_q;
        cr = clr && !s.clr_q;
        n.en_q = en;
        n.clr_q = clr;
        if (cr) begin
            n.done = 0;
            n.periods = 0;
        end
        if (!s.run) begin
            if (er) begin
                n.run = 1; n.count = 0; n.done = 0; n.cyc = 0;
            end
        end else if (!en) begin
            n.run = 0;
        end else begin
            n.cyc = s.cyc + 1;
            if (n.cyc % p == 0) begin
                if (s.count >= load) begin
                    n.done = 1;
                    n.periods = (n.periods + 1) % 64;
                    if (mode) n.count = 0;
                    else n.run = 0;
                end else begin
                    n.count = s.count + 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] m_status(m_t s);
        return {6'(s.periods), s.run, s.done, 24'(s.count)};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1 = m_zero();
            m4 = m_zero();
        end else begin
            m1 = m_step(m1, cfg, 1);
            m4 = m_step(m4, cfg, 4);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_p1", s1, m_status(m1));
        chk("model_p4", s4, m_status(m4));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with config 0
        step(2);
        chk("reset_p1", s1, 32'h0000_0000);
        chk("reset_p4", s4, 32'h0000_0000);
        reset_n = 1'b1;
        step(1);

        // One-shot LOAD=3 at prescale 1
        cfg = 32'h0000_0301;
        step(1);
        chk("oneshot_k0", s1, 32'h0200_0000);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("oneshot_count", s1, 32'h0200_0000 | 32'(k));
        end
        step(1);
        chk("oneshot_done", s1, 32'h0500_0003);
        step(2);
        chk("oneshot_hold", s1, 32'h0500_0003);
        cfg = 32'h0; step(2);
        cfg = 32'h4; step(1);
        cfg = 32'h0; step(1);

        // Periodic LOAD=2 at prescale 4
        cfg = 32'h0000_0203;
        step(1);
        chk("periodic_k0", s4, 32'h0200_0000);
        step(11);
        chk("periodic_k11", s4, 32'h0200_0002);
        step(1);
        chk("periodic_p1", s4, 32'h0700_0000);
        step(12);
        chk("periodic_p2", s4, 32'h0B00_0000);
        step(12);
        chk("periodic_p3", s4, 32'h0F00_0000);

        // CLR rising exactly on the completion edge
        step(11);
        cfg = 32'h0000_0207;
        step(1);
        chk("clr_on_completion", s4, 32'h0700_0000);

        // Lower LOAD below COUNT mid-run
        cfg = 32'h0; step(1);
        cfg = 32'h4; step(1);
        cfg = 32'h0; step(1);
        cfg = 32'h0001_0001;
        step(1);
        step(32'h50);
        chk("load_before", s1, 32'h0200_0050);
        cfg = 32'h0000_1001;
        step(1);
        chk("load_lowered", s1, 32'h0500_0050);
        step(2);
        chk("load_hold", s1, 32'h0500_0050);

        // EN dropped mid-run, then re-raised
        cfg = 32'h4; step(1);
        cfg = 32'h0; step(1);
        cfg = 32'h0000_1001;
        step(1);
        chk("en_start", s1, 32'h0200_0000);
        step(5);
        chk("en_count5", s1, 32'h0200_0005);
        cfg = 32'h0000_1000;
        step(1);
        chk("en_drop", s1, 32'h0000_0005);
        step(2);
        chk("en_drop_hold", s1, 32'h0000_0005);
        cfg = 32'h0000_1001;
        step(1);
        chk("en_restart", s1, 32'h0200_0000);

        // Asynchronous reset mid-run
        step(3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_p1", s1, 32'h0000_0000);
        chk("async_reset_p4", s4, 32'h0000_0000);
        cfg = 32'h0;
        step(1);
        reset_n = 1'b1;
        step(1);

        // LOAD=0 completes on the first tick
        cfg = 32'h0000_0001;
        step(1);
        chk("load0_k0", s4, 32'h0200_0000);
        step(1);
        chk("load0_p1", s1, 32'h0500_0000);
        step(3);
        chk("load0_p4", s4, 32'h0500_0000);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_periph.md
Name: timer_periph

Overview:
- Memory-mapped timer peripheral on the data-memory config/status path.
- Consumes the 32-bit config word that software writes to the config slot, word address 10 (byte 0x28).
- Produces the 32-bit status word that software reads from the status slot, word address 11 (byte 0x2C).
- Counts prescaled clock ticks up to a software-loaded limit, in one-shot or periodic mode, and reports the live count, a sticky done flag, a busy flag and a period counter.

Parameters:
PRESCALE, 4, clock cycles per count tick; legal range 1..65535; 1 means a tick every cycle.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
config_register  input  32  config word from data memory: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] CLR, [7:3] reserved/ignored, [31:8] LOAD (24-bit limit).
status_register  output  32  status word to data memory: [23:0] COUNT, [24] DONE, [25] BUSY, [31:26] PERIODS.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- All state is flopped; status_register is driven only from flops, never combinationally from config_register.
- Reset (reset_n=0, takes effect immediately):
  - state=IDLE; COUNT=0, DONE=0, PERIODS=0, prescaler=0.
  - EN/CLR edge-detect flops=0, so status_register=0x00000000.
- Edge detect: en_q and clr_q hold last-cycle EN and CLR.
  - en_rise = EN & ~en_q; clr_rise = CLR & ~clr_q.
  - A level already high at reset release counts as a rising edge on the first clock.
- States:
  - IDLE: BUSY=0. On en_rise: COUNT=0, prescaler=0, DONE=0, go RUN.
  - RUN: BUSY=1.
    - Each cycle, prescaler increments; tick when prescaler==PRESCALE-1, then prescaler=0.
    - On tick, if COUNT >= LOAD: completion. DONE=1 and PERIODS+1 (6-bit, wraps 63->0).
      - MODE=1: COUNT=0, stay RUN.
      - MODE=0: COUNT holds, go HALT.
    - On tick, otherwise: COUNT+1.
    - EN=0 in RUN: go IDLE next edge; COUNT and DONE hold, prescaler=0.
  - HALT: BUSY=0, COUNT holds. On en_rise: restart as from IDLE. EN=0 is a no-op, since the next rise restarts anyway.
- Comparison uses the live LOAD every tick:
  - Lowering LOAD below COUNT mid-run completes on the next tick; COUNT never wraps.
  - LOAD=0 completes on the first tick.
- MODE is sampled live at the completion tick.
- clr_rise clears DONE and PERIODS in any state; it does not touch COUNT or state.
- Same-cycle precedence:
  - completion vs clr_rise: DONE=1, PERIODS=1 (clear applies first, completion increments).
  - en_rise vs clr_rise in IDLE/HALT: both apply; DONE=0, PERIODS=0.
- Latency:
  - en_rise is seen one edge after config_register changes; the state is RUN after that edge, with COUNT=0.
  - With PRESCALE=P and LOAD=N, DONE rises (N+1)*P edges after the start edge.
- Reset mid-run: asynchronous return to the reset values; the run is lost.
- Bits [7:3] are ignored; status bits are read-only, and writes to the status slot have no effect on this block.

Test Plan:
- Reset with config=0 -> status=0x00000000. Assert reset_n=0 mid-RUN -> status=0 immediately, without waiting for a clock edge.
- PRESCALE=1, config=0x00000301 (LOAD=3, one-shot, EN) -> COUNT 0,1,2,3 on successive edges; DONE=1, PERIODS=1 and BUSY=0 on the 4th edge after start; COUNT holds 3.
- PRESCALE=4, config=0x00000203 (LOAD=2, periodic) -> DONE after 12 cycles; COUNT returns to 0; PERIODS=1 at 12, 2 at 24, 3 at 36; BUSY stays 1.
- Periodic run with CLR 0->1 on the exact completion edge -> DONE=1, PERIODS=1.
- One-shot LOAD=0x000100; at COUNT=0x50 rewrite LOAD=0x000010 -> completes on the next tick with COUNT=0x50, no wrap.
- One-shot run with EN dropped at COUNT=5 -> IDLE, COUNT holds 5. EN raised again -> COUNT=0, BUSY=1, DONE=0.
